friscv_dmem_responder: RTL and testbench

// - Responder end of the core's data memory interface (mem_en/mem_wr/mem_addr/mem_wdata/mem_strb
//   -> mem_rdata/mem_ready), driven by the ALU for LOAD/STORE.
// - Word-organised scratchpad RAM with byte-strobe writes and programmable wait states.
// - Serves as the data RAM in simulation and in small FPGA builds.
//

---
 rtl/friscv_dmem_responder_pkg.sv | 13 +
 rtl/friscv_dmem_responder_ram_be.sv | 27 ++
 rtl/friscv_dmem_responder.sv | 124 ++++++++++++
 tb/tb_friscv_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: FSM states and wait-counter sizing.
package friscv_dmem_responder_pkg;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_WAIT = 2'd1;
    localparam logic [1:0] DMEM_RESP = 2'd2;

    // The counter only ever holds LATENCY-1, so LATENCY=1 still needs one bit.
    function automatic int dmem_lat_w(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/friscv_dmem_responder_ram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module friscv_ram_be
#(
    parameter int XLEN   = 32,
    parameter int DEPTHW = 10
)
(
    input  logic                aclk,
    input  logic [XLEN/8-1:0]   we,
    input  logic [DEPTHW-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic [XLEN-1:0]     rdata
);

    logic [XLEN-1:0] mem [2**DEPTHW];

    // NOTE: neither the array nor the read register has a reset, so the tools can map this onto block RAM.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < XLEN/8; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/friscv_dmem_responder.sv
// Data-memory responder: captures one request, waits LATENCY cycles, then commits and pulses mem_ready.
module friscv_dmem_responder
    import friscv_dmem_responder_pkg::*;
#(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int DEPTHW  = 10,
    parameter int LATENCY = 1
)
(
    input  logic                aclk,
    input  logic                areset,
    input  logic                srst,
    input  logic                mem_en,
    input  logic                mem_wr,
    input  logic [ADDRW-1:0]    mem_addr,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN/8-1:0]   mem_strb,
    output logic [XLEN-1:0]     mem_rdata,
    output logic                mem_ready,
    output logic                oob_err
);

    localparam int              STRBW    = XLEN/8;
    localparam int              CNTW     = dmem_lat_w(LATENCY);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY-1);

    logic [1:0]         state;
    logic [CNTW-1:0]    cnt;
    logic               req_wr;
    logic               req_oob;
    logic [DEPTHW-1:0]  req_idx;
    logic [XLEN-1:0]    req_wdata;
    logic [STRBW-1:0]   req_strb;

    logic               commit;
    logic [DEPTHW-1:0]  ram_addr;
    logic [STRBW-1:0]   ram_we;
    logic [XLEN-1:0]    ram_rdata;
    logic               unused_byte_offset;

    // Byte offset is the initiator's concern; the responder is word-aligned only.
    assign unused_byte_offset = ^mem_addr[1:0];

    assign commit = (state == DMEM_WAIT) && (cnt == '0);

    // Reading from the live address while idle lets the data be ready even when LATENCY=1.
    assign ram_addr = (state == DMEM_IDLE) ? mem_addr[DEPTHW+1:2] : req_idx;
    assign ram_we   = (commit && req_wr && !req_oob && !srst) ? req_strb : '0;

    friscv_ram_be #(
        .XLEN   (XLEN),
        .DEPTHW (DEPTHW)
    ) u_ram (
        .aclk   (aclk),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (req_wdata),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            oob_err   <= 1'b0;
            req_wr    <= 1'b0;
            req_oob   <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
        end else if (srst) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            oob_err   <= 1'b0;
            req_wr    <= 1'b0;
            req_oob   <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (mem_en) begin
                        req_wr    <= mem_wr;
                        req_oob   <= |(mem_addr >> (DEPTHW+2));
                        req_idx   <= mem_addr[DEPTHW+1:2];
                        req_wdata <= mem_wdata;
                        req_strb  <= mem_strb;
                        cnt       <= CNT_INIT;
                        state     <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_ready <= 1'b1;
                        state     <= DMEM_RESP;
                        if (req_oob) begin
                            oob_err <= 1'b1;
                        end
                        if (!req_wr) begin
                            mem_rdata <= req_oob ? '0 : ram_rdata;
                        end
                    end
                end
                DMEM_RESP: begin
                    mem_ready <= 1'b0;
                    state     <= DMEM_IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    state     <= DMEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_dmem_responder.sv
// Self-checking bench for friscv_dmem_responder: directed vector table, reset corners, latency sweep, random mix.
module tb_friscv_dmem_responder;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_oob;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        oob;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        srst = 1'b0;
    logic        en_m = 1'b0;
    logic        en_1 = 1'b0;
    logic        en_4 = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;

    logic [31:0] rdata_m, rdata_1, rdata_4;
    logic        ready_m, ready_1, ready_4;
    logic        oob_m, oob_1, oob_4;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_last = '0;
    logic        oob_sticky = 1'b0;
    logic [31:0] model [64];
    vec_t        vecs [14];

    always #5 aclk = ~aclk;

    friscv_dmem_responder #(.ADDRW(16), .XLEN(32), .DEPTHW(10), .LATENCY(2)) dut (
        .aclk(aclk), .areset(areset), .srst(srst), .mem_en(en_m), .mem_wr(wr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_strb(strb),
        .mem_rdata(rdata_m), .mem_ready(ready_m), .oob_err(oob_m)
    );

    friscv_dmem_responder #(.ADDRW(16), .XLEN(32), .DEPTHW(10), .LATENCY(1)) dut_l1 (
        .aclk(aclk), .areset(areset), .srst(srst), .mem_en(en_1), .mem_wr(wr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_strb(strb),
        .mem_rdata(rdata_1), .mem_ready(ready_1), .oob_err(oob_1)
    );

    friscv_dmem_responder #(.ADDRW(16), .XLEN(32), .DEPTHW(10), .LATENCY(4)) dut_l4 (
        .aclk(aclk), .areset(areset), .srst(srst), .mem_en(en_4), .mem_wr(wr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_strb(strb),
        .mem_rdata(rdata_4), .mem_ready(ready_4), .oob_err(oob_4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_val, $time);
        end
    endtask

    // Drives one request on the LATENCY=2 instance; expectation is queued at drive, popped at ready.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_o);
        exp_t e;
        int   cyc;
        logic got;
        e.rdata = w ? exp_last : exp_rd;
        e.oob   = exp_o;
        if (!w) exp_last = exp_rd;
        exp_q.push_back(e);
        wr = w; addr = a; wdata = d; strb = s; en_m = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge aclk);
            cyc++;
            got = ready_m;
        end
        check("latency", 32'(cyc), 32'd3);
        e = exp_q.pop_front();
        if (got) begin
            check(w ? "store_rdata_hold" : "load_rdata", rdata_m, e.rdata);
            check("oob_err", 32'(oob_m), 32'(e.oob));
        end
        @(negedge aclk);
        check("single_pulse", 32'(ready_m), 32'd0);
        en_m = 1'b0;
    endtask

    task automatic sweep_req(input int lat, input logic w, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd);
        int          cyc;
        logic        got;
        logic [31:0] rd;
        wr = w; addr = a; wdata = d; strb = s;
        if (lat == 1) en_1 = 1'b1; else en_4 = 1'b1;
        cyc = 0;
        got = 1'b0;
        rd  = '0;
        while (!got && cyc < 20) begin
            @(negedge aclk);
            cyc++;
            got = (lat == 1) ? ready_1 : ready_4;
            rd  = (lat == 1) ? rdata_1 : rdata_4;
        end
        check($sformatf("sweep%0d_latency", lat), 32'(cyc), 32'(lat + 1));
        if (!w) check($sformatf("sweep%0d_rdata", lat), rd, exp_rd);
        @(negedge aclk);
        check($sformatf("sweep%0d_single_pulse", lat), 32'((lat == 1) ? ready_1 : ready_4), 32'd0);
        en_1 = 1'b0;
        en_4 = 1'b0;
    endtask

    task automatic run_random(input int n);
        int          idx;
        logic        oob;
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            model[i] = d;
            do_req(1'b1, 16'(i * 4), d, 4'hF, 32'd0, oob_sticky);
        end
        for (int k = 0; k < n; k++) begin
            oob = ($urandom_range(0, 9) == 0);
            idx = int'($urandom_range(0, 63));
            a   = oob ? 16'($urandom_range(32'h1000, 32'hFFFF)) : 16'(idx * 4 + int'($urandom_range(0, 3)));
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom);
            exp_rd = oob ? 32'd0 : model[idx];
            if (w && !oob) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            oob_sticky = oob_sticky | oob;
            do_req(w, a, d, s, exp_rd, oob_sticky);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0010, 32'h0000AA00, 4'h2, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADAAEF, 1'b0};
        vecs[4]  = '{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADAAEF, 1'b0};
        vecs[6]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 16'h0014, 32'h01020304, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 16'h0013, 32'h0,        4'h0, 32'hDEADAAEF, 1'b1};
        vecs[9]  = '{1'b0, 16'h0014, 32'h0,        4'h0, 32'h01020304, 1'b1};
        vecs[10] = '{1'b1, 16'h8010, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADAAEF, 1'b1};
        vecs[12] = '{1'b1, 16'h0FFC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 16'h0FFC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b1};

        // Reset state while areset is held
        repeat (2) @(negedge aclk);
        check("reset_ready", 32'(ready_m), 32'd0);
        check("reset_rdata", rdata_m, 32'd0);
        check("reset_oob", 32'(oob_m), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                   vecs[i].exp_rdata, vecs[i].exp_oob);
        end

        // areset in the middle of a store's wait: request abandoned, RAM keeps old word
        do_req(1'b1, 16'h0020, 32'h12345678, 4'hF, 32'h0, 1'b1);
        wr = 1'b1; addr = 16'h0020; wdata = 32'hFFFFFFFF; strb = 4'hF; en_m = 1'b1;
        @(negedge aclk);
        #1;
        areset = 1'b1;
        en_m   = 1'b0;
        #1;
        check("areset_ready", 32'(ready_m), 32'd0);
        check("areset_rdata", rdata_m, 32'd0);
        check("areset_oob", 32'(oob_m), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("areset_no_ready", 32'(ready_m), 32'd0);
        end
        exp_last   = '0;
        oob_sticky = 1'b0;
        do_req(1'b0, 16'h0020, 32'h0, 4'h0, 32'h12345678, 1'b0);

        // srst on the commit edge of a store: no write, no ready, rdata cleared
        wr = 1'b1; addr = 16'h0020; wdata = 32'hCAFEF00D; strb = 4'hF; en_m = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        srst = 1'b1;
        en_m = 1'b0;
        @(negedge aclk);
        check("srst_ready", 32'(ready_m), 32'd0);
        check("srst_rdata", rdata_m, 32'd0);
        srst = 1'b0;
        @(negedge aclk);
        check("srst_no_ready", 32'(ready_m), 32'd0);
        exp_last = '0;
        do_req(1'b0, 16'h0020, 32'h0, 4'h0, 32'h12345678, 1'b0);

        // Latency sweep with back-to-back requests
        for (int l = 1; l <= 4; l += 3) begin
            sweep_req(l, 1'b1, 16'h0040, 32'h11223344, 4'hF, 32'h0);
            sweep_req(l, 1'b0, 16'h0040, 32'h0,        4'h0, 32'h11223344);
            sweep_req(l, 1'b1, 16'h0042, 32'hAABBCCDD, 4'h1, 32'h0);
            sweep_req(l, 1'b0, 16'h0041, 32'h0,        4'h0, 32'h112233DD);
        end

        run_random(2000);

        repeat (2) @(negedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
